// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel sequencer.
//   rgb565_t            : 16-bit RGB565 colour word
//   FB_WIDTH/FB_HEIGHT  : default framebuffer geometry (320 x 240)
//   MAX_SHAPES          : largest number of shape hit inputs the palette covers
//   COLOR[0..3]         : per-shape palette, shape i paints COLOR[i]
//   palette()           : colour lookup for one shape index
package fb_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int MAX_SHAPES = 4;

    localparam rgb565_t COLOR [0:3] = '{16'hFC00, 16'hFC05, 16'h07E0, 16'h001F};

    // Colour painted by shape idx when it reports a hit.
    function automatic rgb565_t palette(input logic [1:0] idx);
        rgb565_t c;
        case (idx)
            2'd0:    c = COLOR[0];
            2'd1:    c = COLOR[1];
            2'd2:    c = COLOR[2];
            2'd3:    c = COLOR[3];
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fb_pixel_sequencer_if.sv
// Pixel-stream bundle between the sequencer, the shape units and the TFT driver.
//   pix_req      : driver consumed the current pixel (one-cycle strobe)
//   hit          : per-shape "inside" flags for the current x/y
//   x, y         : current scan position (column, row)
//   pixel        : composed RGB565 colour for x/y
//   pixel_valid  : pixel belongs to the current x/y
//   frame_start  : scan position is (0,0)
//   frame_update : one-cycle pulse, shapes may step their position
//   underrun     : sticky, a request arrived while no pixel was valid
// modport master: the sequencer side.  modport slave: driver/shape-unit side.
interface fb_pixel_sequencer_if #(
    parameter int NUM_SHAPES = 3
);
    logic                  pix_req;
    logic [NUM_SHAPES-1:0] hit;
    logic [8:0]            x;
    logic [7:0]            y;
    logic [15:0]           pixel;
    logic                  pixel_valid;
    logic                  frame_start;
    logic                  frame_update;
    logic                  underrun;

    modport master (
        input  pix_req, hit,
        output x, y, pixel, pixel_valid, frame_start, frame_update, underrun
    );

    modport slave (
        output pix_req, hit,
        input  x, y, pixel, pixel_valid, frame_start, frame_update, underrun
    );
endinterface

// File: rtl/fb_pixel_sequencer_tick_sync_edge.sv
// Brings the slow asynchronous animation tick into the clk domain and
// produces a one-cycle pulse on each rising edge.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   async_in  : asynchronous level input
//   rise_s    : high for one clk cycle after a synchronised rising edge
module tick_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_s
);
    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Decoded from two flops only, so the pulse is glitch-free.
    assign rise_s = sync2_r & ~prev_r;

endmodule

// File: rtl/fb_pixel_sequencer.sv
// Column-major framebuffer scanner feeding the TFT serial driver.
// Walks x/y over WIDTH x HEIGHT (y fastest), waits HIT_LAT cycles for the
// shape units to answer, then registers the composed RGB565 pixel.
// Animation ticks are held pending and released only at the frame wrap.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   anim_tick : slow animation clock, asynchronous to clk
//   bus       : pixel-stream bundle (master side), see fb_pixel_sequencer_if
module fb_pixel_sequencer
    import fb_pkg::*;
#(
    parameter int WIDTH      = FB_WIDTH,
    parameter int HEIGHT     = FB_HEIGHT,
    parameter int NUM_SHAPES = 3,
    parameter int HIT_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 anim_tick,
    fb_pixel_sequencer_if.master bus
);
    localparam logic [8:0] X_LAST   = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST   = 8'(HEIGHT - 1);
    localparam logic [1:0] LAT_INIT = 2'(HIT_LAT);

    logic [8:0] x_r;
    logic [7:0] y_r;
    rgb565_t    pixel_r;
    logic       pixel_valid_r;
    logic [1:0] lat_cnt_r;
    logic       frame_update_r;
    logic       underrun_r;
    logic       tick_pending_r;

    logic       accept_s;
    logic       wrap_s;
    logic       tick_rise_s;
    logic [8:0] x_next_s;
    logic [7:0] y_next_s;
    rgb565_t    pixel_comp_s;

    tick_sync_edge u_tick_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (anim_tick),
        .rise_s   (tick_rise_s)
    );

    // Request acceptance and next scan position (y fastest, then x, then wrap).
    always_comb begin
        accept_s = bus.pix_req & pixel_valid_r;
        wrap_s   = accept_s & (x_r == X_LAST) & (y_r == Y_LAST);
        x_next_s = x_r;
        y_next_s = y_r;
        if (accept_s) begin
            if (y_r != Y_LAST) begin
                y_next_s = y_r + 8'd1;
            end else begin
                y_next_s = 8'd0;
                if (x_r != X_LAST) begin
                    x_next_s = x_r + 9'd1;
                end else begin
                    x_next_s = 9'd0;
                end
            end
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Colour composition: OR of the palette entries of every shape that hits.
    always_comb begin
        pixel_comp_s = 16'h0000;
        for (int i = 0; i < NUM_SHAPES; i++) begin
            if (bus.hit[i]) begin
                pixel_comp_s = pixel_comp_s | palette(2'(i));
            end else begin
                pixel_comp_s = pixel_comp_s;
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= 9'd0;
            y_r <= 8'd0;
        end else begin
            x_r <= x_next_s;
            y_r <= y_next_s;
        end
    end

    // Pixel pipeline: after each position change wait HIT_LAT cycles for the
    // shape units, then capture the composition on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_r       <= 16'h0000;
            pixel_valid_r <= 1'b0;
            lat_cnt_r     <= LAT_INIT;
        end else if (accept_s) begin
            pixel_valid_r <= 1'b0;
            lat_cnt_r     <= LAT_INIT;
        end else if (!pixel_valid_r) begin
            if (lat_cnt_r == 2'd0) begin
                pixel_r       <= pixel_comp_s;
                pixel_valid_r <= 1'b1;
            end else begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end
        end
    end

    // Tick coalescing, frame-boundary release and sticky underrun flag.
    // A tick edge coinciding with a wrap survives into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_pending_r <= 1'b0;
            frame_update_r <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            tick_pending_r <= tick_rise_s | (tick_pending_r & ~wrap_s);
            frame_update_r <= wrap_s & tick_pending_r;
            underrun_r     <= underrun_r | (bus.pix_req & ~pixel_valid_r);
        end
    end

    assign bus.x            = x_r;
    assign bus.y            = y_r;
    assign bus.pixel        = pixel_r;
    assign bus.pixel_valid  = pixel_valid_r;
    assign bus.frame_start  = (x_r == 9'd0) && (y_r == 8'd0);
    assign bus.frame_update = frame_update_r;
    assign bus.underrun     = underrun_r;

endmodule

// File: tb/tb_fb_pixel_sequencer.sv
module tb_fb_pixel_sequencer;

    localparam int NS  = 3;
    localparam int LAT = 1;
    localparam int SW  = 12;    // small instance: many frame wraps
    localparam int SH  = 10;
    localparam int FW  = 320;   // full-size instance
    localparam int FH  = 240;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       anim_tick = 1'b0;
    logic       pix_req   = 1'b0;
    logic       force_en  = 1'b1;
    logic [2:0] force_val = 3'b011;
    logic [7:0] salt      = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: index 0 = small instance, 1 = full instance
    int m_w [2];
    int m_h [2];
    int m_n [2];     // accepted requests since reset, modulo frame size
    int m_c [2];     // edge number of the last position change
    int m_lw[2];     // edge number of the last wrap
    bit m_ur[2];
    bit m_fu[2];
    int edge_no;
    int det_q[$];    // edge numbers at which tick rises become visible to the DUT
    bit tprev;

    always #5 clk = ~clk;

    fb_pixel_sequencer_if #(.NUM_SHAPES(NS)) bus_s ();
    fb_pixel_sequencer_if #(.NUM_SHAPES(NS)) bus_f ();

    assign bus_s.pix_req = pix_req;
    assign bus_f.pix_req = pix_req;

    fb_pixel_sequencer #(.WIDTH(SW), .HEIGHT(SH), .NUM_SHAPES(NS), .HIT_LAT(LAT)) dut_s (
        .clk(clk), .rst_n(rst_n), .anim_tick(anim_tick), .bus(bus_s)
    );

    fb_pixel_sequencer #(.WIDTH(FW), .HEIGHT(FH), .NUM_SHAPES(NS), .HIT_LAT(LAT)) dut_f (
        .clk(clk), .rst_n(rst_n), .anim_tick(anim_tick), .bus(bus_f)
    );

    function automatic logic [2:0] shape_hits(input logic [8:0] px, input logic [7:0] py);
        int v;
        v = int'(px) * 37 + int'(py) * 11 + int'(salt);
        return 3'(v >> 2);
    endfunction

    function automatic logic [15:0] expect_colour(input logic [2:0] h);
        logic [15:0] c;
        c = 16'h0000;
        if (h[0]) c = c | 16'hFC00;
        if (h[1]) c = c | 16'hFC05;
        if (h[2]) c = c | 16'h07E0;
        return c;
    endfunction

    // shape units: one-cycle latency from x/y to hit flags
    always @(posedge clk) begin
        bus_s.hit <= force_en ? force_val : shape_hits(bus_s.x, bus_s.y);
        bus_f.hit <= force_en ? force_val : shape_hits(bus_f.x, bus_f.y);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w[0] = SW; m_h[0] = SH;
        m_w[1] = FW; m_h[1] = FH;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_c[i] = 0; m_lw[i] = 0; m_ur[i] = 1'b0; m_fu[i] = 1'b0;
        end
        edge_no = 0;
        det_q.delete();
        tprev = 1'b0;
    endtask

    function automatic bit valid_now();
        return (edge_no - m_c[0]) >= LAT + 1;
    endfunction

    task automatic model_step(input bit p, input bit t);
        bit vb;
        bit wrap;
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            vb   = (edge_no - 1 - m_c[i]) >= LAT + 1;
            wrap = 1'b0;
            m_fu[i] = 1'b0;
            if (p) begin
                if (vb) begin
                    m_n[i]++;
                    m_c[i] = edge_no;
                    if (m_n[i] == m_w[i] * m_h[i]) begin
                        m_n[i] = 0;
                        wrap = 1'b1;
                    end
                end else begin
                    m_ur[i] = 1'b1;
                end
            end
            if (wrap) begin
                foreach (det_q[k])
                    if (det_q[k] >= m_lw[i] && det_q[k] < edge_no) m_fu[i] = 1'b1;
                m_lw[i] = edge_no;
            end
        end
        if (t && !tprev) det_q.push_back(edge_no + 2);
        tprev = t;
    endtask

    task automatic compare_inst(input int i, input string tag,
                                input logic [8:0] dx, input logic [7:0] dy,
                                input logic [15:0] dpix, input logic dval,
                                input logic dfs, input logic dfu, input logic dur);
        int ex;
        int ey;
        bit ev;
        logic [2:0] eh;
        ex = m_n[i] / m_h[i];
        ey = m_n[i] % m_h[i];
        ev = (edge_no - m_c[i]) >= LAT + 1;
        check({tag, ".x"}, 32'(dx), 32'(ex));
        check({tag, ".y"}, 32'(dy), 32'(ey));
        check({tag, ".pixel_valid"}, 32'(dval), 32'(ev));
        check({tag, ".frame_start"}, 32'(dfs), 32'(m_n[i] == 0));
        check({tag, ".frame_update"}, 32'(dfu), 32'(m_fu[i]));
        check({tag, ".underrun"}, 32'(dur), 32'(m_ur[i]));
        if (ev) begin
            eh = force_en ? force_val : shape_hits(9'(ex), 8'(ey));
            check({tag, ".pixel"}, 32'(dpix), 32'(expect_colour(eh)));
        end
    endtask

    task automatic compare_all();
        compare_inst(0, "small", bus_s.x, bus_s.y, bus_s.pixel, bus_s.pixel_valid,
                     bus_s.frame_start, bus_s.frame_update, bus_s.underrun);
        compare_inst(1, "full", bus_f.x, bus_f.y, bus_f.pixel, bus_f.pixel_valid,
                     bus_f.frame_start, bus_f.frame_update, bus_f.underrun);
        if (m_n[1] == 240 && m_c[1] == edge_no) begin
            check("full.column_step.x", 32'(bus_f.x), 32'd1);
            check("full.column_step.y", 32'(bus_f.y), 32'd0);
        end
    endtask

    task automatic cycle(input bit p, input bit t);
        pix_req   = p;
        anim_tick = t;
        @(posedge clk);
        model_step(p, t);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 8 && !valid_now(); k++) cycle(1'b0, 1'b0);
        check("wait_valid.timeout", 32'(valid_now()), 32'd1);
    endtask

    task automatic run_frame(input int tick_a, input int tick_b, output bit fu_wrap, output int pulses);
        bit done;
        bit t;
        done    = 1'b0;
        fu_wrap = 1'b0;
        pulses  = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            t = (m_n[0] == tick_a) || (m_n[0] == tick_b);
            cycle(valid_now(), t);
            if (bus_s.frame_update) pulses++;
            if (m_n[0] == 0 && m_c[0] == edge_no) begin
                done    = 1'b1;
                fu_wrap = bus_s.frame_update;
            end
        end
        check("run_frame.reached_wrap", 32'(done), 32'd1);
    endtask

    initial begin
        bit fu_wrap;
        int pulses;
        bit reached;
        bit p;
        int hold;

        salt = 8'($urandom);
        model_reset();
        #12;
        rst_n = 1'b1;

        // reset state, before the first edge
        compare_all();
        check("reset.x", 32'(bus_s.x), 32'd0);
        check("reset.y", 32'(bus_s.y), 32'd0);
        check("reset.frame_start", 32'(bus_s.frame_start), 32'd1);
        check("reset.pixel", 32'(bus_s.pixel), 32'h0000);
        cycle(1'b0, 1'b0);
        check("reset.valid_after_1clk", 32'(bus_s.pixel_valid), 32'd0);
        cycle(1'b0, 1'b0);
        check("reset.valid_after_2clk", 32'(bus_s.pixel_valid), 32'd1);
        check("compose.hit011", 32'(bus_s.pixel), 32'hFC05);

        // composition literals across three accepted requests
        cycle(1'b1, 1'b0);
        force_val = 3'b100;
        wait_valid();
        check("compose.hit100", 32'(bus_s.pixel), 32'h07E0);
        check("scan.step1", {23'd0, bus_s.x, bus_s.y}, {23'd0, 9'd0, 8'd1});
        cycle(1'b1, 1'b0);
        force_val = 3'b111;
        wait_valid();
        check("compose.hit111", 32'(bus_s.pixel), 32'hFFE5);
        check("scan.step2", {23'd0, bus_s.x, bus_s.y}, {23'd0, 9'd0, 8'd2});
        cycle(1'b1, 1'b0);
        force_en = 1'b0;
        check("scan.step3", {23'd0, bus_s.x, bus_s.y}, {23'd0, 9'd0, 8'd3});

        // tick rise visible exactly at the wrap edge -> deferred one frame
        for (int k = 0; k < 2000; k++) begin
            if (m_n[0] == SW * SH - 1 && m_c[0] == edge_no) break;
            cycle(valid_now(), 1'b0);
        end
        check("tick_wrap.at_last_pixel", 32'(m_n[0] == SW * SH - 1 && m_c[0] == edge_no), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("tick_wrap.frame_start", 32'(bus_s.frame_start), 32'd1);
        check("tick_wrap.deferred", 32'(bus_s.frame_update), 32'd0);
        run_frame(-1, -1, fu_wrap, pulses);
        check("tick_wrap.next_wrap_pulse", 32'(fu_wrap), 32'd1);
        check("tick_wrap.pulse_count", 32'(pulses), 32'd1);
        run_frame(20, 60, fu_wrap, pulses);
        check("coalesce.wrap_pulse", 32'(fu_wrap), 32'd1);
        check("coalesce.pulse_count", 32'(pulses), 32'd1);
        run_frame(-1, -1, fu_wrap, pulses);
        check("no_tick.wrap_pulse", 32'(fu_wrap), 32'd0);
        check("no_tick.pulse_count", 32'(pulses), 32'd0);

        // randomized greedy scan until the full instance sits at (57,99)
        reached = 1'b0;
        hold    = 0;
        for (int k = 0; k < 60000 && n_bad < 200; k++) begin
            if (m_n[1] == 57 * FH + 99 && valid_now()) begin
                reached = 1'b1;
                break;
            end
            p = valid_now() ? ($urandom_range(7) != 0) : 1'b0;
            if (hold > 0) hold--;
            else if ($urandom_range(199) == 0) hold = 3;
            cycle(p, hold > 0);
        end
        check("random.reached_57_99", 32'(reached), 32'd1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        wait_valid();

        // request immediately after an accepted one -> underrun, no advance
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("underrun.set", 32'(bus_f.underrun), 32'd1);
        check("underrun.pos", {23'd0, bus_f.x, bus_f.y}, {23'd0, 9'd57, 8'd100});
        wait_valid();

        // asynchronous reset in mid-frame
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset.x", 32'(bus_f.x), 32'd0);
        check("midreset.y", 32'(bus_f.y), 32'd0);
        check("midreset.underrun", 32'(bus_f.underrun), 32'd0);
        check("midreset.valid", 32'(bus_f.pixel_valid), 32'd0);
        check("midreset.frame_start", 32'(bus_f.frame_start), 32'd1);
        check("midreset.small_pixel", 32'(bus_s.pixel), 32'h0000);
        check("midreset.small_frame_update", 32'(bus_s.frame_update), 32'd0);
        pix_req   = 1'b0;
        anim_tick = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        compare_all();

        // post-reset random traffic including requests while invalid
        hold = 0;
        for (int k = 0; k < 800 && n_bad < 200; k++) begin
            p = ($urandom_range(1) == 1);
            if (hold > 0) hold--;
            else if ($urandom_range(99) == 0) hold = 3;
            cycle(p, hold > 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
